// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_pkg
// Description : Shared constants for the pulse-train detector. It holds the
//               one-hot state codes, the state width and the counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_seq_pkg;

    localparam int unsigned STATE_W = 4;

    // One-hot state codes; any other pattern is treated as illegal
    localparam logic [STATE_W-1:0] ST_IDLE  = 4'b1000;
    localparam logic [STATE_W-1:0] ST_START = 4'b0100;
    localparam logic [STATE_W-1:0] ST_STOP  = 4'b0010;
    localparam logic [STATE_W-1:0] ST_CLEAR = 4'b0001;

    // Bits needed to hold the values 0..n, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_seq_chan.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_chan
// Description : One detector channel. It contains the one-hot FSM, the pulse
//               counter and the STOP-phase timeout counter, and it registers
//               the busy, done and timeout outputs from next-state.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_chan
    import pulse_seq_pkg::*;
#(
    parameter int unsigned PULSES  = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,        // synchronous, active-low
    input  logic en_i,
    input  logic a_i,
    output logic busy_o,
    output logic done_o,
    output logic timeout_o,
    output logic done_next_o   // done one cycle early, used for the aggregate
);

    localparam int unsigned PW = cnt_width(PULSES);
    localparam int unsigned TW = cnt_width(TIMEOUT);

    // When TIMEOUT is 0, TMAX wraps to all ones. tcnt then saturates
    // harmlessly and the timeout compare is disabled.
    localparam logic [PW-1:0] PMAX = PW'(PULSES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PW-1:0]      pcnt_q, pcnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    // State, counters and outputs all load from their next-state values
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            tcnt_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            tcnt_q    <= tcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: a low enable overrides every state rule
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            pcnt_d  = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pcnt_d = '0;
                    tcnt_d = '0;
                    if (a_i) state_d = ST_START;
                end
                ST_START: begin
                    if (!a_i) begin
                        state_d = ST_STOP;
                        tcnt_d  = '0;
                        if (pcnt_q != PMAX) pcnt_d = pcnt_q + PW'(1);
                    end
                end
                ST_STOP: begin
                    // A rising level wins over a coincident timeout
                    if (a_i) begin
                        state_d = (pcnt_q == PMAX) ? ST_CLEAR : ST_START;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TMAX)) begin
                        state_d   = ST_IDLE;
                        pcnt_d    = '0;
                        tcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else if (tcnt_q != TMAX) begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                ST_CLEAR: begin
                    if (!a_i) begin
                        state_d = ST_IDLE;
                        pcnt_d  = '0;
                        tcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                    tcnt_d  = '0;
                end
            endcase
        end
    end

    // Output decode from next-state so the registered flags track the state
    always_comb begin
        busy_d = (state_d == ST_START) || (state_d == ST_STOP);
        done_d = (state_d == ST_CLEAR);
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign done_next_o = done_d;

endmodule
`default_nettype wire

// File: rtl/pulse_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : pulse_seq_detector
// Description : Multi-channel pulse-train detector. It contains CHANNELS
//               independent detector channels and a registered aggregate
//               done output.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_seq_detector
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PULSES   = 1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset,      // synchronous, active-low
    input  logic [CHANNELS-1:0] en_i,
    input  logic [CHANNELS-1:0] a_i,
    output logic [CHANNELS-1:0] busy_o,
    output logic [CHANNELS-1:0] done_o,
    output logic [CHANNELS-1:0] timeout_o,
    output logic                any_done_o
);

    logic [CHANNELS-1:0] done_next;
    logic                any_done_q;

    generate
        for (genvar gi = 0; gi < int'(CHANNELS); gi++) begin : g_chan
            pulse_seq_chan #(
                .PULSES  (PULSES),
                .TIMEOUT (TIMEOUT)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .en_i        (en_i[gi]),
                .a_i         (a_i[gi]),
                .busy_o      (busy_o[gi]),
                .done_o      (done_o[gi]),
                .timeout_o   (timeout_o[gi]),
                .done_next_o (done_next[gi])
            );
        end
    endgenerate

    // The aggregate is built from next-cycle done bits so it lines up with done
    always_ff @(posedge clk) begin
        if (!reset) any_done_q <= 1'b0;
        else        any_done_q <= |done_next;
    end

    assign any_done_o = any_done_q;

endmodule
`default_nettype wire
